// File: rtl/uart_rx_fifo.sv
// Receive FIFO between the UART core and the processor bus: drains the core's
// one-entry buffer into DEPTH {fe,data} entries with a first-word-fall-through read port.
// Optional threshold interrupt enabled by defining UART_RX_FIFO_THRESH_IRQ_EN.
module uart_rx_fifo #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          resetb,
    input  logic [7:0]    core_q,
    input  logic          core_dv,
    input  logic          core_fe,
    input  logic          core_ove,
    output logic          core_rd,
    input  logic          rd,
    output logic [7:0]    q,
    output logic          qfe,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          ovf,
    input  logic          clr_ovf
`ifdef UART_RX_FIFO_THRESH_IRQ_EN
    ,
    input  logic          wrthr,
    input  logic [AW:0]   thr_d,
    output logic          irq
`endif
);

    localparam int DEPTH = 2 ** AW;
    localparam logic [AW:0]   CNT_FULL = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   CNT_ZERO = {(AW+1){1'b0}};
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    logic [8:0]    mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          core_rd_q, core_rd_d;
    logic          cap_s, push_s, pop_s, full_s, empty_s;

    // Masking cap with the pending strobe guarantees each byte is drained once.
    // Pointer, count, strobe and overflow next-state logic.
    always_comb begin
        full_s    = (count_q == CNT_FULL);
        empty_s   = (count_q == CNT_ZERO);
        cap_s     = core_dv & ~core_rd_q;
        pop_s     = rd & ~empty_s;
        push_s    = cap_s & (~full_s | pop_s);
        core_rd_d = cap_s;
        wp_d      = wp_q;
        rp_d      = rp_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        if (push_s) begin
            wp_d = wp_q + PTR_ONE;
        end else begin
            wp_d = wp_q;
        end
        if (pop_s) begin
            rp_d = rp_q + PTR_ONE;
        end else begin
            rp_d = rp_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        // A set condition wins over a same-cycle clear.
        if (cap_s & (core_ove | (full_s & ~pop_s))) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            wp_q      <= PTR_ZERO;
            rp_q      <= PTR_ZERO;
            count_q   <= CNT_ZERO;
            ovf_q     <= 1'b0;
            core_rd_q <= 1'b0;
        end else begin
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            core_rd_q <= core_rd_d;
        end
    end

    // Entry storage; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wp_q] <= {core_fe, core_q};
        end
    end

    assign core_rd = core_rd_q;
    assign q       = mem_q[rp_q][7:0];
    assign qfe     = mem_q[rp_q][8];
    assign empty   = empty_s;
    assign full    = full_s;
    assign count   = count_q;
    assign ovf     = ovf_q;

`ifdef UART_RX_FIFO_THRESH_IRQ_EN
    logic [AW:0] thr_q, thr_next_s;
    logic        irq_q, irq_d;

    // Threshold load and registered interrupt, one cycle behind the count.
    always_comb begin
        thr_next_s = thr_q;
        if (wrthr) begin
            thr_next_s = thr_d;
        end else begin
            thr_next_s = thr_q;
        end
        irq_d = (count_q >= thr_q) | ovf_q;
    end

    // Threshold and interrupt registers.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            thr_q <= CNT_ONE;
            irq_q <= 1'b0;
        end else begin
            thr_q <= thr_next_s;
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (AW=4): capture, framing flag, fill/overflow,
// wrap, full push+pop, overflow-flag priority and asynchronous reset.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       resetb;
    logic [7:0] core_q;
    logic       core_dv, core_fe, core_ove, core_rd;
    logic       rd, qfe, empty, full, ovf, clr_ovf;
    logic [7:0] q;
    logic [4:0] count;
`ifdef UART_RX_FIFO_THRESH_IRQ_EN
    logic       wrthr;
    logic [4:0] thr_d;
    logic       irq;
`endif

    int vectors = 0;
    int miscompares = 0;

    uart_rx_fifo #(.AW(4)) dut (
        .clk(clk), .resetb(resetb), .core_q(core_q), .core_dv(core_dv),
        .core_fe(core_fe), .core_ove(core_ove), .core_rd(core_rd), .rd(rd),
        .q(q), .qfe(qfe), .empty(empty), .full(full), .count(count),
        .ovf(ovf), .clr_ovf(clr_ovf)
`ifdef UART_RX_FIFO_THRESH_IRQ_EN
        , .wrthr(wrthr), .thr_d(thr_d), .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One character from the core: dv for the capture cycle, then the strobe cycle.
    task automatic send(input logic [7:0] b, input logic fe, input logic ove);
        core_q = b; core_fe = fe; core_ove = ove; core_dv = 1'b1;
        tick();
        chk("send_core_rd", 32'(core_rd), 32'd1);
        core_dv = 1'b0; core_ove = 1'b0;
        tick();
    endtask

    task automatic pop();
        rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    initial begin
        resetb = 1'b0; core_q = 8'h00; core_dv = 1'b0; core_fe = 1'b0;
        core_ove = 1'b0; rd = 1'b0; clr_ovf = 1'b0;
`ifdef UART_RX_FIFO_THRESH_IRQ_EN
        wrthr = 1'b0; thr_d = 5'd0;
`endif
        #3;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_core_rd", 32'(core_rd), 32'd0);
        tick();
        resetb = 1'b1;
        tick();

        // Single byte: latency, strobe width, pop.
        core_q = 8'h5A; core_fe = 1'b0; core_dv = 1'b1;
        tick();
        chk("sb_core_rd", 32'(core_rd), 32'd1);
        chk("sb_empty", 32'(empty), 32'd0);
        chk("sb_q", 32'(q), 32'h5A);
        chk("sb_qfe", 32'(qfe), 32'd0);
        chk("sb_count", 32'(count), 32'd1);
        core_dv = 1'b0;
        tick();
        chk("sb_core_rd_low", 32'(core_rd), 32'd0);
        chk("sb_count_hold", 32'(count), 32'd1);
        pop();
        chk("sb_pop_empty", 32'(empty), 32'd1);
        chk("sb_pop_count", 32'(count), 32'd0);
        pop();
        chk("rd_empty_ignored", 32'(count), 32'd0);

        // Framing error stored with its byte.
        send(8'h3C, 1'b1, 1'b0);
        send(8'h77, 1'b0, 1'b0);
        chk("fe_q", 32'(q), 32'h3C);
        chk("fe_qfe", 32'(qfe), 32'd1);
        pop();
        chk("fe_next_q", 32'(q), 32'h77);
        chk("fe_next_qfe", 32'(qfe), 32'd0);
        pop();
        chk("fe_empty", 32'(empty), 32'd1);

        // Fill to DEPTH, then overflow drop.
        for (int i = 0; i < 16; i++) send(8'(i), 1'b0, 1'b0);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd16);
        chk("fill_ovf", 32'(ovf), 32'd0);
        send(8'hAA, 1'b0, 1'b0);
        chk("drop_count", 32'(count), 32'd16);
        chk("drop_ovf", 32'(ovf), 32'd1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain_q%0d", i), 32'(q), 32'(i));
            pop();
        end
        chk("drain_empty", 32'(empty), 32'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("clr_alone_ovf", 32'(ovf), 32'd0);

        // Push/pop 20 across the pointer wrap.
        for (int i = 0; i < 20; i++) begin
            send(8'h40 + 8'(i), 1'b0, 1'b0);
            chk($sformatf("wrap_q%0d", i), 32'(q), 32'h40 + 32'(i));
            pop();
        end
        chk("wrap_empty", 32'(empty), 32'd1);

        // Full with simultaneous capture and pop.
        for (int i = 0; i < 16; i++) send(8'h80 + 8'(i), 1'b0, 1'b0);
        core_q = 8'hEE; core_fe = 1'b0; core_dv = 1'b1; rd = 1'b1;
        tick();
        core_dv = 1'b0; rd = 1'b0;
        chk("fpp_count", 32'(count), 32'd16);
        chk("fpp_ovf", 32'(ovf), 32'd0);
        chk("fpp_head", 32'(q), 32'h81);
        tick();
        for (int i = 0; i < 15; i++) pop();
        chk("fpp_tail", 32'(q), 32'hEE);
        pop();
        chk("fpp_empty", 32'(empty), 32'd1);

        // Core overrun flag, and set-over-clear priority.
        send(8'h11, 1'b0, 1'b1);
        chk("ove_ovf", 32'(ovf), 32'd1);
        chk("ove_stored", 32'(count), 32'd1);
        core_q = 8'h22; core_ove = 1'b1; core_dv = 1'b1; clr_ovf = 1'b1;
        tick();
        core_dv = 1'b0; core_ove = 1'b0; clr_ovf = 1'b0;
        chk("set_over_clr", 32'(ovf), 32'd1);
        tick();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("clr_ovf", 32'(ovf), 32'd0);
        pop();
        pop();
        chk("ove_empty", 32'(empty), 32'd1);

        // Asynchronous reset mid-capture with count=5 and ovf set.
        for (int i = 0; i < 4; i++) send(8'hC0 + 8'(i), 1'b0, 1'b0);
        send(8'hC4, 1'b0, 1'b1);
        chk("pre_rst_count", 32'(count), 32'd5);
        core_q = 8'hD5; core_dv = 1'b1;
        tick();
        chk("pre_rst_core_rd", 32'(core_rd), 32'd1);
        #2;
        resetb = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_ovf", 32'(ovf), 32'd0);
        chk("arst_core_rd", 32'(core_rd), 32'd0);
`ifdef UART_RX_FIFO_THRESH_IRQ_EN
        chk("arst_irq", 32'(irq), 32'd0);
`endif
        tick();
        resetb = 1'b1;
        tick();
        chk("recap_count", 32'(count), 32'd1);
        chk("recap_q", 32'(q), 32'hD5);
        core_dv = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
